// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
//  alu_ctrl_pkg : shared codes, funct constants and sequencer states for
//                 alu_ctrl_md (optional divide support: ALU_CTRL_MD_DIV_EN)
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam logic [3:0] ALU_OR   = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLLV = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_JR   = 4'b1111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_IMM = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_HI  = 2'b01;
    localparam logic [1:0] WB_LO  = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
`ifdef ALU_CTRL_MD_DIV_EN
        MD_DIV  = 2'd2,
`endif
        MD_DONE = 2'd3
    } md_state_t;

    // Functs that launch the sequencer.
    function automatic logic is_muldiv_funct(input logic [5:0] f);
        logic r;
        r = (f == F_MULT) || (f == F_MULTU);
`ifdef ALU_CTRL_MD_DIV_EN
        r = r || (f == F_DIV) || (f == F_DIVU);
`endif
        return r;
    endfunction

    // Functs that depend on HI/LO and must wait for the sequencer.
    function automatic logic is_md_funct(input logic [5:0] f);
        return is_muldiv_funct(f) || (f == F_MFHI) || (f == F_MFLO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_md_seq.sv
// ============================================================================
//  alu_ctrl_md_seq : iterative multiply/divide sequencer with HI/LO registers
//                    (divide datapath only with ALU_CTRL_MD_DIV_EN)
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_md_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic              is_unsigned,
`ifdef ALU_CTRL_MD_DIV_EN
    input  logic              is_div,
`endif
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output md_state_t         state,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    md_state_t               state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [2*DATA_W-1:0]     acc;
    logic [DATA_W-1:0]       opnd;
    logic                    neg_q;
    logic                    last_iter;
    logic [DATA_W-1:0]       mag_a;
    logic [DATA_W-1:0]       mag_b;
    logic [DATA_W:0]         mul_sum;
    logic [2*DATA_W-1:0]     mul_step;
    logic [2*DATA_W-1:0]     prod_fix;

    assign last_iter = (cnt == CNT_W'(DATA_W - 1));
    assign mag_a     = (!is_unsigned && rs_data[DATA_W-1]) ? -rs_data : rs_data;
    assign mag_b     = (!is_unsigned && rt_data[DATA_W-1]) ? -rt_data : rt_data;

    // acc = {partial product, remaining multiplier bits}; shifts right each step.
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]}
                    + (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    assign mul_step = {mul_sum, acc[DATA_W-1:1]};
    assign prod_fix = neg_q ? -acc : acc;

`ifdef ALU_CTRL_MD_DIV_EN
    logic                    op_div;
    logic                    neg_r;
    logic                    div_zero;
    logic [DATA_W:0]         rem_sh;
    logic [DATA_W:0]         rem_diff;
    logic [2*DATA_W-1:0]     div_step;
    logic [DATA_W-1:0]       quo_fix;
    logic [DATA_W-1:0]       rem_fix;

    // acc = {partial remainder, dividend bits shifting into quotient bits}.
    assign rem_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign rem_diff = rem_sh - {1'b0, opnd};
    assign div_step = rem_diff[DATA_W]
                    ? {rem_sh[DATA_W-1:0],   acc[DATA_W-2:0], 1'b0}
                    : {rem_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    assign quo_fix  = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix  = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_MUL;
`ifdef ALU_CTRL_MD_DIV_EN
                    if (is_div) begin
                        state_nxt = (rt_data == '0) ? MD_DONE : MD_DIV;
                    end
`endif
                end
            end
            MD_MUL:  if (last_iter) state_nxt = MD_DONE;
`ifdef ALU_CTRL_MD_DIV_EN
            MD_DIV:  if (last_iter) state_nxt = MD_DONE;
`endif
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef ALU_CTRL_MD_DIV_EN
            op_div   <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        neg_q <= !is_unsigned & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
                        acc   <= {{DATA_W{1'b0}}, mag_b};
                        opnd  <= mag_a;
`ifdef ALU_CTRL_MD_DIV_EN
                        op_div   <= is_div;
                        neg_r    <= !is_unsigned & rs_data[DATA_W-1];
                        div_zero <= (rt_data == '0);
                        if (is_div) begin
                            // A zero divisor keeps the raw dividend for HI.
                            acc  <= {{DATA_W{1'b0}}, (rt_data == '0) ? rs_data : mag_a};
                            opnd <= mag_b;
                        end
`endif
                    end
                end
                MD_MUL: begin
                    acc <= mul_step;
                    cnt <= cnt + 1'b1;
                end
`ifdef ALU_CTRL_MD_DIV_EN
                MD_DIV: begin
                    acc <= div_step;
                    cnt <= cnt + 1'b1;
                end
`endif
                MD_DONE: begin
                    hi <= prod_fix[2*DATA_W-1:DATA_W];
                    lo <= prod_fix[DATA_W-1:0];
`ifdef ALU_CTRL_MD_DIV_EN
                    if (op_div) begin
                        if (div_zero) begin
                            hi <= acc[DATA_W-1:0];
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_md.sv
// ============================================================================
//  alu_ctrl_md : EX-stage ALU control decode plus HI/LO multiply/divide
//                sequencer with hazard stall (divide: ALU_CTRL_MD_DIV_EN)
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_md
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic [1:0]        wb_sel_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_t  state;
    logic [3:0] alu_code;
    logic       r_type;
    logic       md_op;
    logic       muldiv_op;
    logic       start;

    assign r_type    = (ALUOp_i == ALUOP_R);
    assign md_op     = r_type && is_md_funct(funct_i);
    assign muldiv_op = r_type && is_muldiv_funct(funct_i);

    // R-type add/sub codes are swapped relative to ALUOp 00/01, bit-exact
    // with the decoder this block replaces.
    always_comb begin
        alu_code = ALU_OR;
        case (ALUOp_i)
            ALUOP_MEM: alu_code = ALU_ADD;
            ALUOP_BR:  alu_code = ALU_SUB;
            ALUOP_IMM: alu_code = ALU_ADD;
            default: begin
                case (funct_i)
                    F_ADD:   alu_code = ALU_SUB;
                    F_SUB:   alu_code = ALU_ADD;
                    F_AND:   alu_code = ALU_AND;
                    F_OR:    alu_code = ALU_OR;
                    F_SLT:   alu_code = ALU_SLT;
                    F_NOR:   alu_code = ALU_NOR;
                    F_SLL:   alu_code = ALU_SLL;
                    F_SRL:   alu_code = ALU_SRL;
                    F_SLLV:  alu_code = ALU_SLLV;
                    F_SRLV:  alu_code = ALU_SRLV;
                    F_JR:    alu_code = ALU_JR;
                    default: alu_code = ALU_OR;
                endcase
            end
        endcase
    end

    assign ALUCtrl_o = CTRL_W'(alu_code);

    always_comb begin
        wb_sel_o = WB_ALU;
        if (r_type && funct_i == F_MFHI) wb_sel_o = WB_HI;
        if (r_type && funct_i == F_MFLO) wb_sel_o = WB_LO;
    end

    assign busy_o  = (state != MD_IDLE);
    assign stall_o = rst_i & valid_i & md_op & busy_o;
    assign start   = valid_i & muldiv_op & ~stall_o & ~busy_o;

    alu_ctrl_md_seq #(
        .DATA_W      (DATA_W)
    ) u_md_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start       (start),
        .is_unsigned (funct_i[0]),
`ifdef ALU_CTRL_MD_DIV_EN
        .is_div      (funct_i[1]),
`endif
        .rs_data     (rs_data_i),
        .rt_data     (rt_data_i),
        .state       (state),
        .hi          (hi_o),
        .lo          (lo_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_md.sv
// ============================================================================
//  tb_alu_ctrl_md : scoreboard bench for alu_ctrl_md (decode, mult/div, stall)
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [5:0]   funct = 6'b0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic [3:0]   alu_ctrl;
    logic [1:0]   wb_sel;
    logic         stall;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int     checks = 0;
    int     failures = 0;
    longint edge_n = 0;
    logic   busy_prev = 1'b0;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        longint      start;
    } exp_t;

    exp_t scb[$];

    alu_ctrl_md #(.DATA_W(W), .CTRL_W(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .valid_i   (valid),
        .ALUOp_i   (aluop),
        .funct_i   (funct),
        .rs_data_i (rs),
        .rt_data_i (rt),
        .ALUCtrl_o (alu_ctrl),
        .wb_sel_o  (wb_sel),
        .stall_o   (stall),
        .busy_o    (busy),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning.
    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.f = f; e.a = a; e.b = b; e.lat = W + 2; e.start = 0;
        e.hi = '0; e.lo = '0;
        case (f)
            6'b011000: begin p = 64'(sa * sb);             e.hi = p[63:32]; e.lo = p[31:0]; end
            6'b011001: begin p = {32'b0, a} * {32'b0, b};  e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFFFFFF; e.lat = 2;
                end else if (f == 6'b011010) begin
                    q = sa / sb; r = sa % sb;
                    p = 64'(q); e.lo = p[31:0];
                    p = 64'(r); e.hi = p[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        aluop = 2'b10; funct = f; rs = a; rt = b; valid = 1'b1;
        e = model(f, a, b);
        e.start = edge_n + 1;
        scb.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0; aluop = 2'b00; funct = 6'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: each completion (busy falling) pops and checks one result.
    always @(negedge clk) begin
        if (!rst_n) begin
            scb.delete();
            busy_prev <= 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (scb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_unexpected: completion hi=%h lo=%h, required none", hi, lo);
                end else begin
                    exp_t e;
                    e = scb.pop_front();
                    check($sformatf("sb_hi f=%b a=%h b=%h", e.f, e.a, e.b), 64'(hi), 64'(e.hi));
                    check($sformatf("sb_lo f=%b a=%h b=%h", e.f, e.a, e.b), 64'(lo), 64'(e.lo));
                    check($sformatf("sb_latency f=%b", e.f), 64'(edge_n - e.start + 1), 64'(e.lat));
                end
            end
            busy_prev <= busy;
        end
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] d_f [15] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b100111, 6'b000000, 6'b000010, 6'b000100, 6'b000110,
                            6'b001000, 6'b111111, 6'b011000, 6'b010000, 6'b010010};
    logic [3:0] d_c [15] = '{4'b0110, 4'b0010, 4'b0001, 4'b0000, 4'b1100,
                            4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                            4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [1:0] d_w [15] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b00, 2'b00, 2'b01, 2'b10};

    initial begin
        exp_t        ex;
        int          n;
        logic [5:0]  op;
        logic [31:0] last_hi;
        logic [31:0] last_lo;

        // Reset state, with a mult presented so stall must still read 0.
        valid = 1'b1; aluop = 2'b10; funct = 6'b011000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode sweep.
        aluop = 2'b00; #1 check("dec_aluop00", 64'(alu_ctrl), 64'b0010);
        aluop = 2'b01; #1 check("dec_aluop01", 64'(alu_ctrl), 64'b0110);
        aluop = 2'b11; #1 check("dec_aluop11", 64'(alu_ctrl), 64'b0010);
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            aluop = 2'b10; funct = d_f[i];
            #1;
            check($sformatf("dec_funct_%b", d_f[i]), 64'(alu_ctrl), 64'(d_c[i]));
            check($sformatf("wbsel_funct_%b", d_f[i]), 64'(wb_sel), 64'(d_w[i]));
            @(posedge clk); #1;
        end
        check("dec_no_start_busy", 64'(busy), 64'd0);
        aluop = 2'b00; funct = 6'b0;

        // multu 0xFFFFFFFF x 2, busy length.
        issue(6'b011001, 32'hFFFFFFFF, 32'h2);
        wait_idle(n);
        check("multu_busy_len", 64'(n), 64'd33);
        check("multu_hi_direct", 64'(hi), 64'h1);
        check("multu_lo_direct", 64'(lo), 64'hFFFFFFFE);

        // mult -3 x 5 followed immediately by mflo.
        issue(6'b011000, 32'hFFFFFFFD, 32'd5);
        valid = 1'b1; aluop = 2'b10; funct = 6'b010010;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("mflo_stall_len", 64'(n), 64'd33);
        check("mflo_wbsel", 64'(wb_sel), 64'b10);
        check("mflo_lo", 64'(lo), 64'hFFFFFFF1);
        check("mflo_hi", 64'(hi), 64'hFFFFFFFF);
        valid = 1'b0; aluop = 2'b00; funct = 6'b0;
        @(posedge clk); #1;
        last_hi = 32'hFFFFFFFF; last_lo = 32'hFFFFFFF1;

`ifdef ALU_CTRL_MD_DIV_EN
        issue(6'b011010, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        issue(6'b011011, 32'd7, 32'd0);
        wait_idle(n);
        check("divu0_busy_len", 64'(n), 64'd1);
        issue(6'b011010, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        last_hi = 32'h0; last_lo = 32'h80000000;
`else
        // div/divu are unknown functs in this build.
        valid = 1'b1; aluop = 2'b10; funct = 6'b011010; rs = 32'd7; rt = 32'd2;
        #1;
        check("nodiv_code", 64'(alu_ctrl), 64'b0000);
        check("nodiv_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        check("nodiv_busy", 64'(busy), 64'd0);
        funct = 6'b011011; rt = 32'd0;
        @(posedge clk); #1;
        check("nodivu_busy", 64'(busy), 64'd0);
        check("nodiv_hi", 64'(hi), 64'(last_hi));
        check("nodiv_lo", 64'(lo), 64'(last_lo));
        valid = 1'b0; aluop = 2'b00; funct = 6'b0;
`endif

        // Reset in the middle of a mult.
        issue(6'b011000, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clk);
        #1;
        valid = 1'b1; aluop = 2'b10; funct = 6'b010000;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        valid = 1'b0; aluop = 2'b00; funct = 6'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(6'b011000, 32'd1234, 32'hFFFFE9E8);
        wait_idle(n);

        // Back-to-back mults with an independent add in between.
        issue(6'b011001, 32'hDEADBEEF, 32'h00010001);
        valid = 1'b1; aluop = 2'b00;
        #1;
        check("indep_add_stall", 64'(stall), 64'd0);
        check("indep_add_code", 64'(alu_ctrl), 64'b0010);
        @(posedge clk); #1;
        aluop = 2'b10; funct = 6'b011000; rs = 32'hFFFF0000; rt = 32'h7FFF0001;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_stall_len", 64'(n), 64'd32);
        ex = model(6'b011000, 32'hFFFF0000, 32'h7FFF0001);
        ex.start = edge_n + 1;
        scb.push_back(ex);
        @(posedge clk); #1;
        valid = 1'b0; aluop = 2'b00; funct = 6'b0;
        wait_idle(n);

        // Randomised operations, sometimes with an unrelated op during busy.
        for (int i = 0; i < 24; i++) begin
`ifdef ALU_CTRL_MD_DIV_EN
            op = 6'b011000 | 6'($urandom_range(0, 3));
`else
            op = 6'b011000 | 6'($urandom_range(0, 1));
`endif
            issue(op, rnd_val(), rnd_val());
            if ($urandom_range(0, 1) == 1 && busy === 1'b1) begin
                valid = 1'b1; aluop = 2'b01;
                #1;
                check("rand_indep_stall", 64'(stall), 64'd0);
                check("rand_indep_code", 64'(alu_ctrl), 64'b0110);
                valid = 1'b0; aluop = 2'b00;
            end
            wait_idle(n);
        end

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(scb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
- Next-generation ALU control for the pipelined MIPS CPU's EX stage.
- Keeps the existing 2-bit ALUOp / 6-bit funct decode to a 4-bit ALU control code.
- Adds an iterative multiply/divide sequencer with HI/LO registers and a stall output to the hazard unit.
- The CPU instantiates it in place of the combinational decoder. The ALU itself is unchanged.

Parameters:
- DATA_W, 32, operand width and HI/LO register width.
- CTRL_W, 4, ALU control code width.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived; not overridden).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  the EX-stage instruction is real (not a bubble).
- ALUOp_i  input  2  ALU operation class from main control.
- funct_i  input  6  instruction funct field.
- rs_data_i  input  DATA_W  multiplicand or dividend.
- rt_data_i  input  DATA_W  multiplier or divisor.
- ALUCtrl_o  output  CTRL_W  ALU control code (combinational).
- wb_sel_o  output  2  writeback source: 00 ALU, 01 HI, 10 LO (combinational).
- stall_o  output  1  freeze IF/ID/EX and insert a bubble into MEM.
- busy_o  output  1  sequencer not IDLE.
- hi_o  output  DATA_W  HI register.
- lo_o  output  DATA_W  LO register.

Behaviour:
- Decode for ALUOp 00 and 01: ALUOp 00 gives 0010. ALUOp 01 gives 0110.
- Decode for ALUOp 11: gives 0010.
- Decode for ALUOp 10: funct selects the code.
  - 100000 gives 0110; 100010 gives 0010; 100100 gives 0001; 100101 gives 0000.
  - 101010 gives 1100; 100111 gives 0111; 000000 gives 1000; 000010 gives 1001.
  - 000100 gives 1010; 000110 gives 1011; 001000 gives 1111.
  - Mult/div/mf funct codes and any other funct give 0000.
- Multiply/divide ops (ALUOp 10 only): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010.
- wb_sel_o: 01 for mfhi, 10 for mflo, else 00.
- States: IDLE, MUL, DIV, DONE. All register updates occur at clock edges, so ALUCtrl_o never glitches from state.
- IDLE: start condition is valid_i, a mult/div funct, and stall_o low.
  - On start, latch operands. Signed ops latch magnitudes and record result signs.
  - Clear the counter; next state is MUL or DIV.
- MUL: shift-add one bit per cycle for DATA_W cycles, then go to DONE.
- DIV: restoring division, one quotient bit per cycle for DATA_W cycles, then go to DONE.
- DONE: sign-correct the result and write HI/LO in one cycle, then go to IDLE.
  - Multiply result: HI takes product[2*DATA_W-1:DATA_W], LO takes product[DATA_W-1:0].
  - Divide result: LO takes the quotient, HI takes the remainder.
  - Signed divide: remainder sign follows the dividend; quotient truncates toward zero.
- Latency: start edge to HI/LO updated is DATA_W+2 edges (34 at default), i.e. 1 start, DATA_W iterate, 1 DONE.
- Divide by zero is detected at start and goes IDLE to DONE directly. Result: HI equals rs_data_i, LO is all ones, latency 2.
- Signed overflow (0x80000000 / -1): LO is 0x80000000, HI is 0, normal latency.
- stall_o = valid_i & (mult/div/mfhi/mflo) & (state != IDLE).
  - This includes DONE, so an mfhi issued in DONE stalls one cycle and then reads the updated HI.
  - A non-HI/LO instruction never stalls; independent instructions proceed during iteration.
- A start instruction does not stall itself.
- busy_o = (state != IDLE).
- Reset (at any time, including mid-operation): state IDLE, HI/LO 0, counter 0, busy_o 0. stall_o is 0 while rst_i is low.

Optional Feature:
- Macro ALU_CTRL_MD_DIV_EN.
- Defined: div/divu are supported as described above.
- Undefined:
  - DIV state and the divide datapath are absent.
  - div/divu decode as ordinary unknown funct: ALUCtrl_o 0000, no start, no stall, HI/LO unchanged.
  - Multiply and mf behaviour are identical in both builds.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU control code constants (ALU_ADD=0010, ALU_SUB=0110, ... ALU_JR=1111).
  - ALUOp constants.
  - Funct constants, including the new MD/MF codes.
  - The md_state enum.
  - wb_sel constants.
- One sub-module is natural: md_seq (FSM, counter, shift datapath, HI/LO).
- The top keeps the combinational decode plus stall logic.

Test Plan:
- Decode sweep: ALUOp 00 gives 0010; ALUOp 01 gives 0110; ALUOp 11 gives 0010. ALUOp 10 across all 11 funct codes gives the listed codes; funct 111111 gives 0000.
- multu 0xFFFFFFFF x 0x00000002 gives HI 0x00000001 and LO 0xFFFFFFFE, exactly 34 edges after the start edge. busy_o is high for 33 cycles.
- mult -3 x 5, immediately followed by mflo: stall_o high until IDLE, then wb_sel_o 10 and LO 0xFFFFFFF1, HI 0xFFFFFFFF.
- div -7 / 2 gives LO 0xFFFFFFFD and HI 0xFFFFFFFF. divu 7 / 0 gives LO 0xFFFFFFFF and HI 7 after 2 edges (with ALU_CTRL_MD_DIV_EN).
- Assert rst_i low at iteration 10 of a mult: busy_o and HI/LO go to 0 asynchronously. After release, a new mult completes correctly.
- Back-to-back mult while busy: second stalls until IDLE, then starts. An add in between has stall_o 0 and ALUCtrl_o 0010.
